rx_ber_checker: RTL and testbench
=================================

Name: rx_ber_checker

Overview:
- Receive-end companion to the PRBS9-fed transmitter.
- Takes the transmitter's 8-bit signed oversampled stream (OS samples per symbol) and decimates it at a selectable phase.
- Slices each kept sample to a bit and locks a local PRBS9 (x^9+x^5+1) to the received sequence.
- Counts compared bits and bit errors for BER measurement.

Parameters:
- NB_DATA, 8: sample width, two's complement.
- OS, 4: samples per symbol; the sample counter runs 0..OS-1.
- LOCK_WIN, 64: bits per lock-qualification window.
- LOCK_MAX_ERR, 4: maximum errors per window that still count as locked.
- NB_CNT, 32: width of the bit and error counters.

Ports:
- clk, in, 1: sample clock, one i_rx sample per cycle.
- rst, in, 1: asynchronous, active-low reset.
- i_enable, in, 1: 0 freezes all state (counters, FSM, LFSR).
- i_phase, in, 2: sampling phase 0..OS-1.
- i_clear, in, 1: synchronous clear of o_bit_count and o_err_count.
- i_rx, in, NB_DATA: received sample, signed.
- o_bit, out, 1: sliced bit.
- o_bit_valid, out, 1: one-cycle strobe qualifying o_bit.
- o_lock, out, 1: PRBS lock indicator.
- o_bit_count, out, NB_CNT: number of bits compared while LOCKED.
- o_err_count, out, NB_CNT: number of mismatches while LOCKED.

Behaviour:
- Reset (rst=0, asynchronous):
  - sample counter = 0; FSM = SEED; hist[8:0] = 0; seed count = 0.
  - Window bit and error counters = 0.
  - All outputs = 0.
- Decimation:
  - With i_enable=1, the sample counter increments every cycle and wraps OS-1 -> 0.
  - A strobe fires in a cycle where counter == i_phase.
  - i_phase >= OS never strobes.
  - A change of i_phase takes effect on the next compare; no automatic resync.
- Slicer:
  - On strobe, d = ~i_rx[NB_DATA-1], so a sample >= 0 gives 1 and a negative sample gives 0.
  - o_bit <= d and o_bit_valid <= 1 one cycle after the strobe cycle (latency 1).
  - o_bit_valid = 0 otherwise.
- Reference LFSR:
  - hist[0] holds the newest bit.
  - Expected bit e = hist[8] ^ hist[4], matching the generator recurrence b[n] = b[n-9] ^ b[n-5].
- FSM, evaluated on each strobe only:
  - SEED: hist <= {hist[7:0], d}. After 9 bits, go to CHECK; clear the window counters.
  - CHECK: hist <= {hist[7:0], e} (free-running); the window error count increments when d != e. When LOCK_WIN bits are done:
    - errors <= LOCK_MAX_ERR: go to LOCKED, o_lock <= 1.
    - otherwise: go to SEED.
  - LOCKED: free-running as in CHECK. Each strobe increments o_bit_count; a mismatch also increments o_err_count. The window is re-evaluated every LOCK_WIN bits:
    - errors > LOCK_MAX_ERR: go to SEED, o_lock <= 0. Global counters keep their values.
    - otherwise: stay LOCKED.
  - The window counters reset at every window boundary.
- Counters:
  - o_bit_count and o_err_count saturate at 2^NB_CNT-1.
  - When the bit counter saturates, both counters freeze.
- i_clear:
  - Zeroes both global counters next cycle. It has priority over increments in the same cycle.
  - FSM, lock and window state are unaffected.
- i_enable=0: everything holds, o_bit_valid = 0. Resuming continues from the held state.
- Reset mid-operation: immediate return to the reset state, o_lock = 0, resync from SEED.
- A single channel bit error costs exactly one error count, because the LFSR free-runs in CHECK/LOCKED and errors do not propagate.

Test Plan:
1. Clean lock:
   - Stimulus: PRBS9 with seed 9'b010101011, mapped 1 -> +64 and 0 -> -64, each value held 4 samples, i_phase=2.
   - Required: o_lock rises after 9+64 = 73 strobes; after 1000 further bits, o_bit_count=1000 and o_err_count=0.
2. Isolated errors:
   - Stimulus: same stream, locked; negate the sample sign of 3 symbols spaced 100 bits apart.
   - Required: o_err_count=3 exactly, o_lock stays 1.
3. Lock loss and reacquire:
   - Stimulus: replace the input with all-sign-alternating random data for 200 bits, then restore the PRBS.
   - Required: o_lock falls at the first window with >4 errors; it relocks 73 strobes after clean data resumes the SEED fill; counters retain their pre-loss values plus the new counts.
4. Phase and slicing:
   - Stimulus: input 0 -> bit 1, input -1 -> bit 0; i_phase=3 gives strobes every 4th cycle at counter 3; set OS=4 with i_phase=3.
   - Required: o_bit_valid period is 4 cycles, lagging the strobe by 1.
5. Clear and saturation:
   - Stimulus: assert i_clear while locked; separately, NB_CNT=4 with 20 bits of input.
   - Required: i_clear gives counters 0 on the next cycle; NB_CNT=4 gives o_bit_count=15 and o_err_count held.
6. Async reset mid-LOCKED:
   - Stimulus: drive rst low between clock edges.
   - Required: all outputs go to 0 immediately; after rst returns high, o_lock reasserts after 73 strobes.

Source files
------------

// File: rtl/rx_ber_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// rx_ber_checker
// Receive-side BER checker for a PRBS9 (x^9+x^5+1) oversampled stream.
// Decimates the incoming signed sample stream at a selectable phase, slices
// each kept sample to a bit, locks a local PRBS9 to the received sequence and
// counts compared bits / bit errors while locked.
//
// Ports:
//   clk          sample clock, one i_rx sample per cycle
//   rst          asynchronous, active-low reset
//   i_enable     1 = run, 0 = freeze all state
//   i_phase      decimation phase 0..OS-1 (values >= OS never strobe)
//   i_clear      synchronous clear of the global bit/error counters
//   i_rx         received sample, two's complement
//   o_bit        sliced bit (valid with o_bit_valid)
//   o_bit_valid  one-cycle strobe, one cycle after the decimation strobe
//   o_lock       PRBS lock indicator
//   o_bit_count  bits compared while locked (saturating)
//   o_err_count  mismatches while locked (saturating)
// -----------------------------------------------------------------------------
module rx_ber_checker #(
   parameter int NB_DATA      = 8,
   parameter int OS           = 4,
   parameter int LOCK_WIN     = 64,
   parameter int LOCK_MAX_ERR = 4,
   parameter int NB_CNT       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_enable,
   input  logic [1:0]         i_phase,
   input  logic               i_clear,
   input  logic [NB_DATA-1:0] i_rx,
   output logic               o_bit,
   output logic               o_bit_valid,
   output logic               o_lock,
   output logic [NB_CNT-1:0]  o_bit_count,
   output logic [NB_CNT-1:0]  o_err_count
);

   localparam int CNT_W = (OS > 1) ? $clog2(OS) : 1;
   localparam int WIN_W = $clog2(LOCK_WIN + 1);

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   samp_cnt_reg;
   logic [8:0]         hist_reg;
   logic [3:0]         seed_cnt_reg;
   logic [WIN_W-1:0]   win_bits_reg;
   logic [WIN_W-1:0]   win_errs_reg;
   logic               bit_reg;
   logic               bit_valid_reg;
   logic               lock_reg;
   logic [NB_CNT-1:0]  bit_cnt_reg;
   logic [NB_CNT-1:0]  err_cnt_reg;

   logic               strobe;
   logic               d;
   logic               e;
   logic               mism;
   logic               win_last;
   logic [WIN_W-1:0]   win_errs_next;
   logic               win_ok;

   // Decimation strobe: the sample counter never exceeds OS-1, so a phase
   // >= OS simply never matches.
   assign strobe = i_enable && (32'(i_phase) == 32'(samp_cnt_reg));

   // Slicer: non-negative sample -> 1, negative -> 0 (i.e. inverted sign bit).
   assign d = ($signed(i_rx) >= $signed({NB_DATA{1'b0}}));

   // Reference bit from history, hist[0] newest: b[n] = b[n-9] ^ b[n-5].
   assign e    = hist_reg[8] ^ hist_reg[4];
   assign mism = d ^ e;

   // Window bookkeeping includes the current strobe's mismatch so the
   // decision at the window's last bit sees all LOCK_WIN comparisons.
   assign win_last      = (win_bits_reg == WIN_W'(LOCK_WIN - 1));
   assign win_errs_next = win_errs_reg + {{(WIN_W-1){1'b0}}, mism};
   assign win_ok        = (32'(win_errs_next) <= LOCK_MAX_ERR);

   // Sample counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp_cnt_reg <= '0;
      end else if (i_enable) begin
         if (samp_cnt_reg == CNT_W'(OS - 1))
            samp_cnt_reg <= '0;
         else
            samp_cnt_reg <= samp_cnt_reg + 1'b1;
      end
   end

   // Slicer output register (latency 1 from the strobe)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_reg       <= 1'b0;
         bit_valid_reg <= 1'b0;
      end else begin
         bit_valid_reg <= strobe;
         if (strobe)
            bit_reg <= d;
      end
   end

   // Lock FSM with reference history and window counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= SEED;
         hist_reg     <= '0;
         seed_cnt_reg <= '0;
         win_bits_reg <= '0;
         win_errs_reg <= '0;
         lock_reg     <= 1'b0;
      end else if (strobe) begin
         case (state_reg)
            SEED: begin
               // Fill the history straight from the channel.
               hist_reg <= {hist_reg[7:0], d};
               if (seed_cnt_reg == 4'd8) begin
                  seed_cnt_reg <= '0;
                  win_bits_reg <= '0;
                  win_errs_reg <= '0;
                  state_reg    <= CHECK;
               end else begin
                  seed_cnt_reg <= seed_cnt_reg + 1'b1;
               end
            end
            CHECK, LOCKED: begin
               // Free-running reference: channel errors never enter the
               // history, so each one costs exactly one error count.
               hist_reg <= {hist_reg[7:0], e};
               if (win_last) begin
                  win_bits_reg <= '0;
                  win_errs_reg <= '0;
                  if (win_ok) begin
                     state_reg <= LOCKED;
                     lock_reg  <= 1'b1;
                  end else begin
                     state_reg    <= SEED;
                     seed_cnt_reg <= '0;
                     lock_reg     <= 1'b0;
                  end
               end else begin
                  win_bits_reg <= win_bits_reg + 1'b1;
                  win_errs_reg <= win_errs_next;
               end
            end
            default: begin
               state_reg    <= SEED;
               seed_cnt_reg <= '0;
               lock_reg     <= 1'b0;
            end
         endcase
      end
   end

   // Global BER counters: count only in LOCKED, freeze both once the bit
   // counter saturates, clear wins over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt_reg <= '0;
         err_cnt_reg <= '0;
      end else if (i_enable) begin
         if (i_clear) begin
            bit_cnt_reg <= '0;
            err_cnt_reg <= '0;
         end else if (strobe && (state_reg == LOCKED) && (bit_cnt_reg != '1)) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (mism && (err_cnt_reg != '1))
               err_cnt_reg <= err_cnt_reg + 1'b1;
         end
      end
   end

   assign o_bit       = bit_reg;
   assign o_bit_valid = bit_valid_reg;
   assign o_lock      = lock_reg;
   assign o_bit_count = bit_cnt_reg;
   assign o_err_count = err_cnt_reg;

endmodule

// File: tb/tb_rx_ber_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_rx_ber_checker
// Directed bench for rx_ber_checker. Two instances share the stimulus: one
// with 32-bit counters, one with 4-bit counters for saturation behaviour.
// The PRBS9 source is seeded with 9'b010101011, bits mapped 1 -> +64 and
// 0 -> -64, each held for 4 samples with the decimation phase at 2.
// -----------------------------------------------------------------------------
module tb_rx_ber_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_enable;
   logic [1:0] i_phase;
   logic       i_clear;
   logic [7:0] i_rx;

   logic        a_bit, a_valid, a_lock;
   logic [31:0] a_bits, a_errs;
   logic        b_bit, b_valid, b_lock;
   logic [3:0]  b_bits, b_errs;

   int checks = 0;
   int errors = 0;

   logic [8:0] gen = 9'b010101011;
   int         m44 = 0;

   always #5 clk = ~clk;

   rx_ber_checker #(.NB_CNT(32)) dut_a (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_phase(i_phase),
      .i_clear(i_clear), .i_rx(i_rx), .o_bit(a_bit), .o_bit_valid(a_valid),
      .o_lock(a_lock), .o_bit_count(a_bits), .o_err_count(a_errs)
   );

   rx_ber_checker #(.NB_CNT(4)) dut_b (
      .clk(clk), .rst(rst), .i_enable(i_enable), .i_phase(i_phase),
      .i_clear(i_clear), .i_rx(i_rx), .o_bit(b_bit), .o_bit_valid(b_valid),
      .o_lock(b_lock), .o_bit_count(b_bits), .o_err_count(b_errs)
   );

   // Next bit of the transmitted PRBS9: b[n] = b[n-9] ^ b[n-5]
   function automatic logic prbs_next();
      logic nb;
      nb  = gen[8] ^ gen[4];
      gen = {gen[7:0], nb};
      return nb;
   endfunction

   // One symbol = 4 samples; optional i_clear in the last sample (after the strobe)
   task automatic send_sym(input logic b, input logic clr);
      for (int i = 0; i < 4; i++) begin
         i_rx    = b ? 8'h40 : 8'hC0;
         i_clear = clr && (i == 3);
         @(posedge clk);
         #1;
      end
      i_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; i_enable = 1'b1; i_phase = 2'd2; i_clear = 1'b0; i_rx = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_lock !== 1'b0)   begin errors++; $display("FAIL reset_lock got=%0d exp=0", a_lock); end
      checks++; if (a_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%0d exp=0", a_valid); end
      checks++; if (a_bit !== 1'b0)    begin errors++; $display("FAIL reset_bit got=%0d exp=0", a_bit); end
      checks++; if (a_bits !== 32'd0)  begin errors++; $display("FAIL reset_bit_count got=%0d exp=0", a_bits); end
      checks++; if (a_errs !== 32'd0)  begin errors++; $display("FAIL reset_err_count got=%0d exp=0", a_errs); end
      $display("test_reset: lock=%0d valid=%0d bits=%0d errs=%0d", a_lock, a_valid, a_bits, a_errs);
      rst = 1'b1;
   endtask

   task automatic test_clean_lock();
      for (int i = 1; i <= 73; i++) begin
         send_sym(prbs_next(), 1'b0);
         if (i == 72) begin
            checks++; if (a_lock !== 1'b0) begin errors++; $display("FAIL lock_at_72 got=%0d exp=0", a_lock); end
         end
      end
      checks++; if (a_lock !== 1'b1) begin errors++; $display("FAIL lock_at_73 got=%0d exp=1", a_lock); end
      checks++; if (a_bits !== 32'd0) begin errors++; $display("FAIL bits_at_lock got=%0d exp=0", a_bits); end
      repeat (1000) send_sym(prbs_next(), 1'b0);
      checks++; if (a_bits !== 32'd1000) begin errors++; $display("FAIL clean_bit_count got=%0d exp=1000", a_bits); end
      checks++; if (a_errs !== 32'd0)    begin errors++; $display("FAIL clean_err_count got=%0d exp=0", a_errs); end
      checks++; if (a_lock !== 1'b1)     begin errors++; $display("FAIL clean_lock got=%0d exp=1", a_lock); end
      $display("test_clean_lock: lock=%0d bits=%0d errs=%0d", a_lock, a_bits, a_errs);
   endtask

   task automatic test_isolated_errors();
      logic b;
      for (int i = 0; i < 300; i++) begin
         b = prbs_next();
         send_sym((i == 50 || i == 150 || i == 250) ? ~b : b, 1'b0);
      end
      checks++; if (a_errs !== 32'd3)    begin errors++; $display("FAIL iso_err_count got=%0d exp=3", a_errs); end
      checks++; if (a_bits !== 32'd1300) begin errors++; $display("FAIL iso_bit_count got=%0d exp=1300", a_bits); end
      checks++; if (a_lock !== 1'b1)     begin errors++; $display("FAIL iso_lock got=%0d exp=1", a_lock); end
      $display("test_isolated_errors: lock=%0d bits=%0d errs=%0d", a_lock, a_bits, a_errs);
   endtask

   // 1300 locked bits so far = 20 windows + 20 bits: the window closes 44 bits
   // into the noise, which is where the lock must drop.
   task automatic test_loss_reacquire();
      logic e, r;
      int   idx;
      for (int i = 1; i <= 200; i++) begin
         e = prbs_next();
         r = ((i % 4) == 0) ? ~e : 1'($urandom_range(0, 1));
         if (i <= 44 && r != e) m44++;
         send_sym(r, 1'b0);
         if (i == 43) begin
            checks++; if (a_lock !== 1'b1) begin errors++; $display("FAIL loss_lock_43 got=%0d exp=1", a_lock); end
         end
         if (i == 44) begin
            checks++; if (a_lock !== 1'b0) begin errors++; $display("FAIL loss_lock_44 got=%0d exp=0", a_lock); end
         end
      end
      checks++; if (a_bits !== 32'd1344) begin errors++; $display("FAIL loss_bit_count got=%0d exp=1344", a_bits); end
      checks++; if (a_errs !== 32'(3 + m44)) begin errors++; $display("FAIL loss_err_count got=%0d exp=%0d", a_errs, 3 + m44); end
      idx = 0;
      for (int i = 1; i <= 300 && idx == 0; i++) begin
         send_sym(prbs_next(), 1'b0);
         if (a_lock === 1'b1) idx = i;
      end
      checks++; if (idx < 73 || idx > 146) begin errors++; $display("FAIL relock_index got=%0d exp=73..146", idx); end
      checks++; if (a_bits !== 32'd1344) begin errors++; $display("FAIL relock_bit_count got=%0d exp=1344", a_bits); end
      repeat (100) send_sym(prbs_next(), 1'b0);
      checks++; if (a_bits !== 32'd1444) begin errors++; $display("FAIL reacq_bit_count got=%0d exp=1444", a_bits); end
      checks++; if (a_errs !== 32'(3 + m44)) begin errors++; $display("FAIL reacq_err_count got=%0d exp=%0d", a_errs, 3 + m44); end
      $display("test_loss_reacquire: relock_idx=%0d bits=%0d errs=%0d", idx, a_bits, a_errs);
   endtask

   task automatic test_clear_saturation();
      logic b;
      send_sym(prbs_next(), 1'b1);
      checks++; if (a_bits !== 32'd0) begin errors++; $display("FAIL clear_bits_a got=%0d exp=0", a_bits); end
      checks++; if (a_errs !== 32'd0) begin errors++; $display("FAIL clear_errs_a got=%0d exp=0", a_errs); end
      checks++; if (b_bits !== 4'd0)  begin errors++; $display("FAIL clear_bits_b got=%0d exp=0", b_bits); end
      checks++; if (a_lock !== 1'b1)  begin errors++; $display("FAIL clear_lock got=%0d exp=1", a_lock); end
      repeat (20) send_sym(prbs_next(), 1'b0);
      checks++; if (a_bits !== 32'd20) begin errors++; $display("FAIL sat_bits_a got=%0d exp=20", a_bits); end
      checks++; if (b_bits !== 4'd15)  begin errors++; $display("FAIL sat_bits_b got=%0d exp=15", b_bits); end
      b = prbs_next();
      send_sym(~b, 1'b0);
      checks++; if (a_errs !== 32'd1) begin errors++; $display("FAIL sat_errs_a got=%0d exp=1", a_errs); end
      checks++; if (b_errs !== 4'd0)  begin errors++; $display("FAIL sat_errs_b got=%0d exp=0", b_errs); end
      checks++; if (b_bits !== 4'd15) begin errors++; $display("FAIL sat_hold_b got=%0d exp=15", b_bits); end
      $display("test_clear_saturation: a_bits=%0d a_errs=%0d b_bits=%0d b_errs=%0d", a_bits, a_errs, b_bits, b_errs);
   endtask

   task automatic test_enable();
      i_enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         i_rx = 8'($urandom);
         @(posedge clk);
         #1;
         checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL disabled_valid cyc=%0d got=%0d exp=0", i, a_valid); end
      end
      checks++; if (a_bits !== 32'd21) begin errors++; $display("FAIL disabled_bits got=%0d exp=21", a_bits); end
      i_enable = 1'b1;
      repeat (10) send_sym(prbs_next(), 1'b0);
      checks++; if (a_bits !== 32'd31) begin errors++; $display("FAIL resume_bits got=%0d exp=31", a_bits); end
      checks++; if (a_errs !== 32'd1)  begin errors++; $display("FAIL resume_errs got=%0d exp=1", a_errs); end
      checks++; if (a_lock !== 1'b1)   begin errors++; $display("FAIL resume_lock got=%0d exp=1", a_lock); end
      $display("test_enable: lock=%0d bits=%0d errs=%0d", a_lock, a_bits, a_errs);
   endtask

   task automatic test_async_reset();
      logic b;
      b = prbs_next();
      for (int i = 0; i < 3; i++) begin
         i_rx = b ? 8'h40 : 8'hC0;
         @(posedge clk);
         #1;
      end
      checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%0d exp=1", a_valid); end
      rst = 1'b0;
      #1;
      checks++; if (a_lock !== 1'b0)  begin errors++; $display("FAIL async_lock got=%0d exp=0", a_lock); end
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%0d exp=0", a_valid); end
      checks++; if (a_bit !== 1'b0)   begin errors++; $display("FAIL async_bit got=%0d exp=0", a_bit); end
      checks++; if (a_bits !== 32'd0) begin errors++; $display("FAIL async_bits got=%0d exp=0", a_bits); end
      checks++; if (a_errs !== 32'd0) begin errors++; $display("FAIL async_errs got=%0d exp=0", a_errs); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 1; i <= 73; i++) begin
         send_sym(prbs_next(), 1'b0);
         if (i == 72) begin
            checks++; if (a_lock !== 1'b0) begin errors++; $display("FAIL rst_lock_72 got=%0d exp=0", a_lock); end
         end
      end
      checks++; if (a_lock !== 1'b1) begin errors++; $display("FAIL rst_lock_73 got=%0d exp=1", a_lock); end
      repeat (10) send_sym(prbs_next(), 1'b0);
      checks++; if (a_bits !== 32'd10) begin errors++; $display("FAIL rst_bits got=%0d exp=10", a_bits); end
      $display("test_async_reset: lock=%0d bits=%0d errs=%0d", a_lock, a_bits, a_errs);
   endtask

   // Phase 3: strobe on the 4th sample of each group, o_bit_valid one cycle
   // later; non-strobe samples carry the opposite sign.
   task automatic test_phase_slicing();
      logic [7:0] sv [4];
      logic       ex [4];
      sv[0] = 8'h00; ex[0] = 1'b1;
      sv[1] = 8'hFF; ex[1] = 1'b0;
      sv[2] = 8'h7F; ex[2] = 1'b1;
      sv[3] = 8'h80; ex[3] = 1'b0;
      i_phase = 2'd3;
      for (int k = 0; k < 16; k++) begin
         if ((k % 4) == 3) i_rx = sv[k / 4];
         else              i_rx = ex[k / 4] ? 8'hC0 : 8'h40;
         @(posedge clk);
         #1;
         checks++;
         if (a_valid !== ((k % 4) == 3)) begin
            errors++; $display("FAIL phase_valid cyc=%0d got=%0d exp=%0d", k, a_valid, ((k % 4) == 3));
         end
         if ((k % 4) == 3) begin
            checks++;
            if (a_bit !== ex[k / 4]) begin
               errors++; $display("FAIL slice_bit rx=%0d got=%0d exp=%0d", $signed(sv[k / 4]), a_bit, ex[k / 4]);
            end
         end
      end
      $display("test_phase_slicing: done, last bit=%0d", a_bit);
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_isolated_errors();
      test_loss_reacquire();
      test_clear_saturation();
      test_enable();
      test_async_reset();
      test_phase_slicing();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
